// File: rtl/instr_seq_if.sv
// Fetch-side ROM port and execute-side bundle handshake of the instruction sequencer.
// master = sequencer, slave = ROM / execute environment.
interface instr_seq_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_vld;
  logic [DATA_W-1:0] fetch_data;

  logic              exec_valid;
  logic              exec_ready;
  logic [DATA_W-1:0] exec_instr;
  logic [DATA_W-1:0] exec_src_ext;
  logic [DATA_W-1:0] exec_dst_ext;
  logic [ADDR_W-1:0] exec_pc;
  logic [1:0]        exec_len;
  logic              exec_illegal;

  modport master (
    output fetch_req, fetch_addr,
    input  fetch_vld, fetch_data,
    output exec_valid, exec_instr, exec_src_ext, exec_dst_ext, exec_pc, exec_len, exec_illegal,
    input  exec_ready
  );

  modport slave (
    input  fetch_req, fetch_addr,
    output fetch_vld, fetch_data,
    input  exec_valid, exec_instr, exec_src_ext, exec_dst_ext, exec_pc, exec_len, exec_illegal,
    output exec_ready
  );
endinterface

// File: rtl/instr_seq.sv
// MSP430 fetch/decode sequencer: ROM prefetch queue, extension-word collection,
// and a registered instruction bundle presented with valid/ready; flush redirects fetch.
module instr_seq #(
  parameter int                 DATA_W   = 16,
  parameter int                 ADDR_W   = 16,
  parameter int                 QDEPTH   = 4,
  parameter logic [ADDR_W-1:0]  RESET_PC = 16'hF800
) (
  input  logic              clk,
  input  logic              rst_n,
  instr_seq_if.master       bus,
  input  logic              flush,
  input  logic [ADDR_W-1:0] flush_addr
);
  localparam int                PW       = $clog2(QDEPTH);
  localparam int                CW       = PW + 1;
  localparam logic [CW-1:0]     DEPTH    = CW'(QDEPTH);
  localparam logic [ADDR_W-1:0] WORD_MSK = ~ADDR_W'(1);

  typedef enum logic [1:0] {S_OPC, S_SRC, S_DST, S_ISSUE} state_t;

  logic [DATA_W-1:0] q_data [QDEPTH];
  logic [ADDR_W-1:0] q_addr [QDEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count;
  logic [ADDR_W-1:0] fetch_addr;

  state_t            state;
  logic              need_dst;
  logic              exec_valid, exec_illegal;
  logic [DATA_W-1:0] exec_instr, exec_src_ext, exec_dst_ext;
  logic [ADDR_W-1:0] exec_pc;
  logic [1:0]        exec_len;

  logic              fetch_req, push, pop;
  logic [DATA_W-1:0] head_data;
  logic [ADDR_W-1:0] head_addr;
  logic              dec_src, dec_dst, dec_ill;

  // Source word needed for indexed/symbolic/absolute (As=01, except R3 constants) and immediate (@PC+).
  function automatic logic src_word(input logic [3:0] sreg, input logic [1:0] as_mode);
    return (as_mode == 2'b01 && sreg != 4'd3) || (as_mode == 2'b11 && sreg == 4'd0);
  endfunction

  assign fetch_req = (count < DEPTH) && !flush;
  assign push      = fetch_req && bus.fetch_vld;
  assign pop       = !flush && (count != '0) && (state != S_ISSUE);
  assign head_data = q_data[rd_ptr];
  assign head_addr = q_addr[rd_ptr];

  always_comb begin
    dec_src = 1'b0;
    dec_dst = 1'b0;
    dec_ill = 1'b0;
    if (head_data[15:12] == 4'b0000) begin
      dec_ill = 1'b1;
    end else if (head_data[15:12] == 4'b0001) begin
      dec_src = src_word(head_data[3:0], head_data[5:4]);
    end else if (head_data[15:12] >= 4'd4) begin
      dec_src = src_word(head_data[11:8], head_data[5:4]);
      dec_dst = head_data[7];
    end
  end

  // NOTE: queue storage is not reset; count and the pointers alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      q_data[wr_ptr] <= bus.fetch_data;
      q_addr[wr_ptr] <= fetch_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      fetch_addr <= RESET_PC & WORD_MSK;
    end else if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      fetch_addr <= flush_addr & WORD_MSK;
    end else begin
      if (push) begin
        wr_ptr     <= wr_ptr + PW'(1);
        fetch_addr <= fetch_addr + ADDR_W'(2);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_OPC;
      need_dst     <= 1'b0;
      exec_valid   <= 1'b0;
      exec_instr   <= '0;
      exec_src_ext <= '0;
      exec_dst_ext <= '0;
      exec_pc      <= '0;
      exec_len     <= '0;
      exec_illegal <= 1'b0;
    end else if (flush) begin
      // A bundle handshaken in this cycle is already consumed, so dropping it loses nothing.
      state      <= S_OPC;
      exec_valid <= 1'b0;
    end else begin
      case (state)
        S_OPC: if (pop) begin
          exec_instr   <= head_data;
          exec_pc      <= head_addr;
          exec_src_ext <= '0;
          exec_dst_ext <= '0;
          exec_len     <= 2'd1 + 2'(dec_src) + 2'(dec_dst);
          exec_illegal <= dec_ill;
          need_dst     <= dec_dst;
          if (dec_src)      state <= S_SRC;
          else if (dec_dst) state <= S_DST;
          else begin
            state      <= S_ISSUE;
            exec_valid <= 1'b1;
          end
        end
        S_SRC: if (pop) begin
          exec_src_ext <= head_data;
          if (need_dst) state <= S_DST;
          else begin
            state      <= S_ISSUE;
            exec_valid <= 1'b1;
          end
        end
        S_DST: if (pop) begin
          exec_dst_ext <= head_data;
          state        <= S_ISSUE;
          exec_valid   <= 1'b1;
        end
        S_ISSUE: if (bus.exec_ready) begin
          state      <= S_OPC;
          exec_valid <= 1'b0;
        end
        default: state <= S_OPC;
      endcase
    end
  end

  assign bus.fetch_req    = fetch_req;
  assign bus.fetch_addr   = fetch_addr;
  assign bus.exec_valid   = exec_valid;
  assign bus.exec_instr   = exec_instr;
  assign bus.exec_src_ext = exec_src_ext;
  assign bus.exec_dst_ext = exec_dst_ext;
  assign bus.exec_pc      = exec_pc;
  assign bus.exec_len     = exec_len;
  assign bus.exec_illegal = exec_illegal;
endmodule

// File: tb/tb_instr_seq.sv
// Scoreboard bench for instr_seq: a program-walking model queues expected bundles,
// a negedge monitor pops and compares them on every handshake.
module tb_instr_seq;
  localparam logic [15:0] RESET_PC = 16'hF800;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic [15:0] flush_addr;

  instr_seq_if #(.DATA_W(16), .ADDR_W(16)) bus ();

  instr_seq #(.DATA_W(16), .ADDR_W(16), .QDEPTH(4), .RESET_PC(RESET_PC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .flush      (flush),
    .flush_addr (flush_addr)
  );

  always #5 clk = ~clk;

  logic [15:0] rom [32768];
  assign bus.fetch_data = rom[bus.fetch_addr[15:1]];

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] src;
    logic [15:0] dst;
    logic [15:0] pc;
    logic [1:0]  len;
    logic        ill;
  } bundle_t;

  bundle_t     exp_q[$];
  logic [15:0] model_pc;
  int          checks = 0;
  int          failures = 0;
  int          handshakes = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_bundle(input string tag, input bundle_t e);
    check({tag, "_instr"},   32'(bus.exec_instr),   32'(e.instr));
    check({tag, "_src_ext"}, 32'(bus.exec_src_ext), 32'(e.src));
    check({tag, "_dst_ext"}, 32'(bus.exec_dst_ext), 32'(e.dst));
    check({tag, "_pc"},      32'(bus.exec_pc),      32'(e.pc));
    check({tag, "_len"},     32'(bus.exec_len),     32'(e.len));
    check({tag, "_illegal"}, 32'(bus.exec_illegal), 32'(e.ill));
  endtask

  // Reference: walk the program word by word from a byte address using MSP430 addressing rules.
  function automatic bundle_t model_bundle(input logic [15:0] pc, output logic [15:0] next_pc);
    bundle_t     b;
    logic [15:0] op, a_src, a_dst;
    logic [3:0]  sreg;
    logic [1:0]  as_mode;
    bit          has_src, has_dst;
    int          n;
    op      = rom[pc[15:1]];
    has_src = 0;
    has_dst = 0;
    sreg    = 4'd0;
    as_mode = 2'd0;
    case (op[15:12])
      4'h0, 4'h2, 4'h3: ;
      4'h1: begin sreg = op[3:0]; as_mode = op[5:4]; end
      default: begin sreg = op[11:8]; as_mode = op[5:4]; has_dst = op[7]; end
    endcase
    if (op[15:12] == 4'h1 || op[15:12] >= 4'h4)
      has_src = (as_mode == 2'b01 && sreg != 4'd3) || (as_mode == 2'b11 && sreg == 4'd0);
    n       = 1 + int'(has_src) + int'(has_dst);
    a_src   = pc + 16'd2;
    a_dst   = pc + (has_src ? 16'd4 : 16'd2);
    b.instr = op;
    b.pc    = pc;
    b.ill   = (op[15:12] == 4'h0);
    b.src   = has_src ? rom[a_src[15:1]] : 16'h0000;
    b.dst   = has_dst ? rom[a_dst[15:1]] : 16'h0000;
    b.len   = 2'(n);
    next_pc = pc + 16'(2 * n);
    return b;
  endfunction

  task automatic refill();
    bundle_t     b;
    logic [15:0] nxt;
    while (exp_q.size() < 4) begin
      b = model_bundle(model_pc, nxt);
      exp_q.push_back(b);
      model_pc = nxt;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    refill();
  endtask

  // Caller sets exec_ready for this cycle first: a bundle accepted alongside flush stays expected.
  task automatic do_flush(input logic [15:0] addr);
    bundle_t b;
    flush      = 1'b1;
    flush_addr = addr;
    if (bus.exec_valid && bus.exec_ready) begin
      b = exp_q[0];
      exp_q.delete();
      exp_q.push_back(b);
    end else begin
      exp_q.delete();
    end
    model_pc = addr & 16'hFFFE;
    refill();
  endtask

  task automatic do_reset();
    flush = 1'b0;
    rst_n = 1'b0;
    exp_q.delete();
    model_pc = RESET_PC;
    cycle();
    rst_n = 1'b1;
  endtask

  task automatic wait_valid(input string name, input int budget);
    int n = 0;
    while (!bus.exec_valid && n < budget) begin
      cycle();
      n++;
    end
    check(name, 32'(bus.exec_valid), 32'd1);
  endtask

  always @(negedge clk) begin
    bundle_t e;
    if (rst_n && bus.exec_valid && bus.exec_ready) begin
      handshakes++;
      check("sb_has_entry", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check_bundle("sb", e);
      end
    end
  end

  initial begin
    for (int i = 0; i < 32768; i++) rom[i] = 16'($urandom);
    // MOV R4,R5 / MOV #0x1234,&0x0200 / MOV #1,R5 / CALL 4(R5) / JMP / illegal
    rom[16'hF800 >> 1] = 16'h4405;
    rom[16'hF802 >> 1] = 16'h40B2;
    rom[16'hF804 >> 1] = 16'h1234;
    rom[16'hF806 >> 1] = 16'h0200;
    rom[16'hF808 >> 1] = 16'h4315;
    rom[16'hF80A >> 1] = 16'h1295;
    rom[16'hF80C >> 1] = 16'h0004;
    rom[16'hF80E >> 1] = 16'h3C05;
    rom[16'hF810 >> 1] = 16'h0000;
    rom[16'h2000 >> 1] = 16'h40B2;
    rom[16'h2002 >> 1] = 16'h5555;
    rom[16'h2004 >> 1] = 16'h6666;
    rom[16'hF900 >> 1] = 16'h4405;

    rst_n          = 1'b0;
    flush          = 1'b0;
    flush_addr     = 16'h0000;
    bus.fetch_vld  = 1'b0;
    bus.exec_ready = 1'b0;
    model_pc       = RESET_PC;
    repeat (3) cycle();

    check("rst_exec_valid", 32'(bus.exec_valid), 32'd0);
    check("rst_exec_instr", 32'(bus.exec_instr), 32'd0);
    check("rst_exec_ext",   32'({bus.exec_src_ext, bus.exec_dst_ext}), 32'd0);
    check("rst_exec_pc",    32'(bus.exec_pc), 32'd0);
    check("rst_exec_len",   32'({bus.exec_len, bus.exec_illegal}), 32'd0);
    check("rst_fetch_addr", 32'(bus.fetch_addr), 32'hF800);
    check("rst_fetch_req",  32'(bus.fetch_req), 32'd1);
    exp_q.delete();
    model_pc = RESET_PC;
    refill();
    rst_n = 1'b1;

    // Back-pressure: hold the first bundle for 10 cycles while the queue fills.
    bus.fetch_vld = 1'b1;
    wait_valid("first_valid", 20);
    for (int i = 0; i < 10; i++) begin
      cycle();
      check("stall_valid", 32'(bus.exec_valid), 32'd1);
      check_bundle("stall", exp_q[0]);
    end
    check("full_fetch_req", 32'(bus.fetch_req), 32'd0);
    bus.exec_ready = 1'b1;
    cycle();
    check("release_valid_drop", 32'(bus.exec_valid), 32'd0);
    cycle();
    check("release_fetch_resume", 32'(bus.fetch_req), 32'd1);

    // Rest of the directed program under random ROM latency.
    for (int i = 0; i < 60; i++) begin
      bus.fetch_vld = ($urandom % 4) != 0;
      cycle();
    end

    // Flush while collecting the source word of a 3-word instruction.
    bus.fetch_vld = 1'b0;
    do_flush(16'h2000);
    cycle();
    flush = 1'b0;
    bus.fetch_vld = 1'b1;
    cycle();
    bus.fetch_vld = 1'b0;
    cycle();
    cycle();
    check("src_stall_valid", 32'(bus.exec_valid), 32'd0);
    do_flush(16'hF901);
    cycle();
    flush = 1'b0;
    check("flush_addr_align", 32'(bus.fetch_addr), 32'hF900);
    for (int i = 0; i < 40; i++) begin
      bus.fetch_vld = ($urandom % 4) != 0;
      cycle();
    end

    // Fetch address wraps past the top of the address space.
    bus.fetch_vld = 1'b0;
    do_flush(16'hFFFE);
    cycle();
    flush = 1'b0;
    check("wrap_start", 32'(bus.fetch_addr), 32'hFFFE);
    bus.fetch_vld = 1'b1;
    cycle();
    check("wrap_to_zero", 32'(bus.fetch_addr), 32'h0000);
    for (int i = 0; i < 40; i++) begin
      bus.fetch_vld = ($urandom % 4) != 0;
      cycle();
    end

    // Reset while a bundle waits for acceptance.
    bus.exec_ready = 1'b0;
    bus.fetch_vld  = 1'b1;
    wait_valid("pre_reset_valid", 20);
    do_reset();
    check("issue_reset_valid", 32'(bus.exec_valid), 32'd0);
    check("issue_reset_fetch", 32'(bus.fetch_addr), 32'hF800);
    check("issue_reset_instr", 32'(bus.exec_instr), 32'd0);

    // Random traffic: ROM latency, back-pressure, redirects and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      int r;
      bus.fetch_vld  = ($urandom % 4) != 0;
      bus.exec_ready = ($urandom % 10) < 7;
      r = int'($urandom % 500);
      if (r == 0) begin
        do_reset();
      end else begin
        if (r < 10) do_flush(16'($urandom));
        else flush = 1'b0;
        cycle();
      end
    end
    flush          = 1'b0;
    bus.exec_ready = 1'b1;
    repeat (10) cycle();
    check("handshake_volume", 32'(handshakes > 200), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
